// File: rtl/mux_arb_pkg.sv
// Shared constants for the 2:1 mux bus arbiter: state/select encodings,
// default widths and the round-robin pick helper.
package mux_arb_pkg;

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   localparam logic SEL_REQ0 = 1'b0;
   localparam logic SEL_REQ1 = 1'b1;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_CNT_WIDTH  = 8;

   // Under contention, serve whoever was not served last.
   function automatic logic rr_pick(input logic last_served);
      return (last_served == SEL_REQ0) ? SEL_REQ1 : SEL_REQ0;
   endfunction

endpackage

// File: rtl/mux2_bus_arbiter_mux.sv
// Shared 2:1 datapath mux used by the bus arbiter; S selects I1 when high.
module Mux_2x1_8bit
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH
) (
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic             S,
   output logic [WIDTH-1:0] Y
);

   assign Y = (S == SEL_REQ1) ? I1 : I0;

endmodule

// File: rtl/mux2_bus_arbiter.sv
// Two-requester arbiter over a shared 2:1 mux feeding a one-entry valid/ready
// output register. MUX_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins).
module mux2_bus_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  REQ0,
   input  logic [DATA_WIDTH-1:0] DATA0,
   output logic                  ACK0,
   input  logic                  REQ1,
   input  logic [DATA_WIDTH-1:0] DATA1,
   output logic                  ACK1,
   output logic                  SEL,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   output logic [CNT_WIDTH-1:0]  XFER_CNT
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic                  r_state;
   logic                  r_ack0;
   logic                  r_ack1;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [CNT_WIDTH-1:0]  r_xfer_cnt;

   logic                  w_can_load;
   logic                  w_drain;
   logic                  w_elig0;
   logic                  w_elig1;
   logic                  w_grant;
   logic                  w_sel;
   logic [DATA_WIDTH-1:0] w_mux_y;

`ifndef MUX_ARB_FIXED_PRIO_EN
   logic                  r_last_served;
`endif

   assign w_drain    = (r_state == ST_FULL) && OUT_READY;
   assign w_can_load = (r_state == ST_EMPTY) || OUT_READY;
   // A requester acked this cycle still shows its old word on REQ/DATA.
   assign w_elig0    = REQ0 && !r_ack0;
   assign w_elig1    = REQ1 && !r_ack1;
   assign w_grant    = w_can_load && (w_elig0 || w_elig1);

   always_comb begin
      w_sel = SEL_REQ0;
      if (w_can_load) begin
         if (w_elig0 && w_elig1) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
            w_sel = SEL_REQ0;
`else
            w_sel = rr_pick(r_last_served);
`endif
         end else if (w_elig1) begin
            w_sel = SEL_REQ1;
         end
      end
   end

   Mux_2x1_8bit #(.WIDTH(DATA_WIDTH)) u_mux (
      .I0 (DATA0),
      .I1 (DATA1),
      .S  (w_sel),
      .Y  (w_mux_y)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state    <= ST_EMPTY;
         r_out_data <= '0;
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_xfer_cnt <= '0;
      end else begin
         r_ack0 <= w_grant && (w_sel == SEL_REQ0);
         r_ack1 <= w_grant && (w_sel == SEL_REQ1);
         if (w_grant) begin
            r_out_data <= w_mux_y;
            r_state    <= ST_FULL;
         end else if (w_drain) begin
            r_state    <= ST_EMPTY;
         end
         if (w_drain)
            r_xfer_cnt <= r_xfer_cnt + CNT_ONE;
      end
   end

`ifndef MUX_ARB_FIXED_PRIO_EN
   // Reset to requester 1 so requester 0 wins the first contention.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         r_last_served <= SEL_REQ1;
      else if (w_grant)
         r_last_served <= w_sel;
   end
`endif

   assign SEL       = w_sel;
   assign ACK0      = r_ack0;
   assign ACK1      = r_ack1;
   assign OUT_VALID = (r_state == ST_FULL);
   assign OUT_DATA  = r_out_data;
   assign XFER_CNT  = r_xfer_cnt;

endmodule

// File: doc/mux2_bus_arbiter.md
Name: mux2_bus_arbiter

Overview:
- Shares one 8-bit 2:1 mux datapath between two requesters.
- Arbitrates, drives the mux select, captures the selected word into a one-entry output register, and hands it downstream with a valid/ready handshake.
- Sits between producer units (e.g. ALU result and immediate/load path) and a single-consumer bus in the 8-bit processor.

Parameters:
- DATA_WIDTH, 8, width of requester data, mux datapath and OUT_DATA.
- CNT_WIDTH, 8, width of the transfer counter XFER_CNT.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ0  input  1  requester 0 has a word; held until ACK0.
- DATA0  input  DATA_WIDTH  requester 0 word; stable while REQ0=1.
- ACK0  output  1  one-cycle pulse: DATA0 captured.
- REQ1  input  1  requester 1 has a word; held until ACK1.
- DATA1  input  DATA_WIDTH  requester 1 word.
- ACK1  output  1  one-cycle pulse: DATA1 captured.
- SEL  output  1  mux select; combinational, 1 = DATA1.
- OUT_VALID  output  1  output register holds a word.
- OUT_READY  input  1  downstream accepts when OUT_VALID=1.
- OUT_DATA  output  DATA_WIDTH  registered output word.
- XFER_CNT  output  CNT_WIDTH  count of completed downstream transfers.

Behaviour:
- Clocking and reset: single clock CLK; asynchronous active-high reset RESET.
- Reset values:
  - OUT_VALID=0, OUT_DATA=0, ACK0=0, ACK1=0, XFER_CNT=0.
  - last_served=1, so requester 0 wins the first contention.
- States:
  - EMPTY (OUT_VALID=0).
  - FULL (OUT_VALID=1).
- can_load = EMPTY, or FULL with OUT_READY=1 (drain and reload in the same cycle).
- Eligibility: REQx=1 and ACKx=0. A requester acked this cycle is ineligible this cycle, because its REQ still reflects the old word.
- Grant, combinational:
  - If can_load=0 → no grant.
  - If can_load=1 and one requester is eligible → that requester.
  - If both are eligible → the one != last_served (round-robin).
- SEL = granted index; SEL=0 when no grant.
- On the edge with a grant:
  - OUT_DATA ← selected word; OUT_VALID ← 1.
  - ACKx ← 1 for exactly the next cycle.
  - last_served ← x.
- Latency: REQ seen eligible in cycle N → OUT_VALID/ACK high in cycle N+1.
- Drain:
  - OUT_VALID=1 and OUT_READY=1 on an edge → XFER_CNT+1.
  - OUT_VALID ← 0 unless reloaded the same edge.
- XFER_CNT wraps 2^CNT_WIDTH-1 → 0.
- Backpressure: while FULL and OUT_READY=0:
  - OUT_DATA is held.
  - No grant, no ACK.
  - SEL=0.
- Throughput with OUT_READY=1:
  - Both requesting → one word per cycle, alternating 0,1,0,1.
  - Single requester → one word per two cycles (ineligible in its ACK cycle).
- REQ dropped before ACK: the word is withdrawn, no ACK, no error.
- Reset mid-operation: the pending word is dropped without a transfer count; a held ACK is cleared immediately.

Optional Feature:
- Macro: MUX_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins contention and last_served is ignored; requester 1 is served only when requester 0 is ineligible.
- Undefined: round-robin as above (default build).

Decomposition:
- Shared package mux_arb_pkg:
  - State encoding constants ST_EMPTY=1'b0, ST_FULL=1'b1.
  - Select constants SEL_REQ0=1'b0, SEL_REQ1=1'b1.
  - Default widths DATA_WIDTH=8, CNT_WIDTH=8.
- Sub-module: instantiate the existing Mux_2x1_8bit as the datapath (I0=DATA0, I1=DATA1, S=SEL). Arbitration and registers remain in mux2_bus_arbiter.

Test Plan:
- Reset then idle, OUT_READY=1, no REQ for 5 cycles → OUT_VALID=0, ACK0/ACK1=0, XFER_CNT=0, SEL=0.
- REQ0=1, DATA0=8'd10, OUT_READY=1:
  - Next cycle OUT_DATA=10, OUT_VALID=1, ACK0=1.
  - Following cycle REQ0 dropped → XFER_CNT=1.
- REQ0 and REQ1 held with DATA0=8'd10, DATA1=8'd20, OUT_READY=1 → OUT_DATA sequence 10,20,10,20, ACKs alternate, XFER_CNT increments every cycle.
- OUT_READY=0 while FULL with OUT_DATA=8'd4 and REQ1 pending:
  - 3 cycles: OUT_DATA stays 4, ACK1=0, SEL=0.
  - OUT_READY=1 → same edge drains and loads DATA1.
- Preload XFER_CNT to 255 via 255 transfers, then one more → XFER_CNT=0.
- Assert RESET asynchronously while OUT_VALID=1 and ACK1=1 → both 0 immediately, before the next CLK edge; after release, first contention grants requester 0.
